expr_stream_checker: RTL and testbench

- Character-serial recognizer for arithmetic expressions arriving one ASCII byte per accepted cycle.
- Generalises the single-digit digit-operator-digit checker:
  - multi-digit operands
  - operators + - * /
  - parentheses with bounded nesting depth
  - operand counting
  - sticky error reporting
- Sits behind the UART/keyboard byte path in the test/demo datapath. Drives a "valid so far" flag.

---
 rtl/expr_pkg.sv | 37 +++
 rtl/expr_char_class.sv | 36 +++
 rtl/expr_stream_checker.sv | 166 ++++++++++++++++
 tb/tb_expr_stream_checker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared types and constants for the expression stream checker.
//
// Contents:
//   state_t  - recognizer states (S_START, S_NUM, S_OP, S_CLOSE, S_ERR)
//   cls_t    - character classes (DIG, OP, LP, RP, SKIP, BAD)
//   ASC_*    - ASCII codes of every character the decoder distinguishes
package expr_pkg;

    typedef enum logic [2:0] {
        S_START,
        S_NUM,
        S_OP,
        S_CLOSE,
        S_ERR
    } state_t;

    typedef enum logic [2:0] {
        DIG,
        OP,
        LP,
        RP,
        SKIP,
        BAD
    } cls_t;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_STAR  = 8'h2A;
    localparam logic [7:0] ASC_SLASH = 8'h2F;
    localparam logic [7:0] ASC_LPAR  = 8'h28;
    localparam logic [7:0] ASC_RPAR  = 8'h29;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_TAB   = 8'h09;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII-to-class decoder for the expression checker.
//
// Ports:
//   ch   in  8  ASCII character
//   cls  out    character class (cls_t)
//
// Build option: EXPR_SPACE_SKIP_EN - when defined, space and tab decode to
// SKIP; otherwise they decode to BAD like any other unknown character.
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0] ch,
    output cls_t       cls
);

    always_comb begin
        cls = BAD;
        if (ch >= ASC_0 && ch <= ASC_9) begin
            cls = DIG;
        end else if (ch == ASC_PLUS || ch == ASC_MINUS ||
                     ch == ASC_STAR || ch == ASC_SLASH) begin
            cls = OP;
        end else if (ch == ASC_LPAR) begin
            cls = LP;
        end else if (ch == ASC_RPAR) begin
            cls = RP;
        end else if (ch == ASC_SPACE || ch == ASC_TAB) begin
`ifdef EXPR_SPACE_SKIP_EN
            cls = SKIP;
`else
            cls = BAD;
`endif
        end
    end

endmodule

// File: rtl/expr_stream_checker.sv
// Character-serial recognizer for arithmetic expressions. One ASCII byte is
// consumed per clock when in_valid is high; outputs reflect every byte
// accepted up to and including the previous edge.
//
// Ports:
//   clk       in   1        rising-edge clock
//   clr_n     in   1        synchronous active-low reset
//   in_valid  in   1        consume `in` on this edge
//   in        in   8        ASCII character
//   out       out  1        accepted prefix is a complete valid expression
//   err       out  1        sticky error; prefix can no longer be valid
//   depth     out  DEPTH_W  current open-paren depth
//   term_cnt  out  CNT_W    operands seen, saturating at all-ones
//
// Build option: EXPR_SPACE_SKIP_EN - space/tab are skipped instead of being
// errors; whitespace inside a number terminates that number.
module expr_stream_checker
    import expr_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int MAX_DEPTH  = 3,
    parameter int CNT_W      = 8,
    parameter int DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               out,
    output logic               err,
    output logic [DEPTH_W-1:0] depth,
    output logic [CNT_W-1:0]   term_cnt
);

    localparam int DIG_W = $clog2(MAX_DIGITS + 1);
    localparam logic [DIG_W-1:0]   DIG_LIMIT   = DIG_W'(MAX_DIGITS);
    localparam logic [DEPTH_W-1:0] DEPTH_LIMIT = DEPTH_W'(MAX_DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    cls_t               cls;
    state_t             state, state_nx;
    logic [DIG_W-1:0]   digit_cnt, digit_nx;
    logic [DEPTH_W-1:0] depth_nx;
    logic [CNT_W-1:0]   term_nx;
`ifdef EXPR_SPACE_SKIP_EN
    logic               num_closed, closed_nx;
`endif

    expr_char_class u_class (
        .ch  (in),
        .cls (cls)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state     <= S_START;
            digit_cnt <= '0;
            depth     <= '0;
            term_cnt  <= '0;
`ifdef EXPR_SPACE_SKIP_EN
            num_closed <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            digit_cnt <= digit_nx;
            depth     <= depth_nx;
            term_cnt  <= term_nx;
`ifdef EXPR_SPACE_SKIP_EN
            num_closed <= closed_nx;
`endif
        end
    end

    // Any transition to S_ERR leaves the counters untouched, so they freeze
    // at their values from before the failing byte.
    always_comb begin
        state_nx = state;
        digit_nx = digit_cnt;
        depth_nx = depth;
        term_nx  = term_cnt;
`ifdef EXPR_SPACE_SKIP_EN
        closed_nx = num_closed;
`endif
        if (in_valid) begin
            case (state)
                S_START, S_OP: begin
                    case (cls)
                        DIG: begin
                            state_nx = S_NUM;
                            digit_nx = DIG_W'(1);
                            term_nx  = sat_inc(term_cnt);
`ifdef EXPR_SPACE_SKIP_EN
                            closed_nx = 1'b0;
`endif
                        end
                        LP: begin
                            if (depth == DEPTH_LIMIT) state_nx = S_ERR;
                            else                      depth_nx = depth + DEPTH_W'(1);
                        end
`ifdef EXPR_SPACE_SKIP_EN
                        SKIP: ;
`endif
                        default: state_nx = S_ERR;
                    endcase
                end
                S_NUM: begin
                    case (cls)
                        DIG: begin
`ifdef EXPR_SPACE_SKIP_EN
                            // Whitespace already ended this number.
                            if (num_closed) state_nx = S_ERR;
                            else
`endif
                            if (digit_cnt == DIG_LIMIT) state_nx = S_ERR;
                            else                        digit_nx = digit_cnt + DIG_W'(1);
                        end
                        OP: begin
                            state_nx = S_OP;
                            digit_nx = '0;
`ifdef EXPR_SPACE_SKIP_EN
                            closed_nx = 1'b0;
`endif
                        end
                        RP: begin
                            if (depth == '0) begin
                                state_nx = S_ERR;
                            end else begin
                                state_nx = S_CLOSE;
                                depth_nx = depth - DEPTH_W'(1);
                                digit_nx = '0;
`ifdef EXPR_SPACE_SKIP_EN
                                closed_nx = 1'b0;
`endif
                            end
                        end
`ifdef EXPR_SPACE_SKIP_EN
                        SKIP: closed_nx = 1'b1;
`endif
                        default: state_nx = S_ERR;
                    endcase
                end
                S_CLOSE: begin
                    case (cls)
                        OP: state_nx = S_OP;
                        RP: begin
                            if (depth == '0) state_nx = S_ERR;
                            else             depth_nx = depth - DEPTH_W'(1);
                        end
`ifdef EXPR_SPACE_SKIP_EN
                        SKIP: ;
`endif
                        default: state_nx = S_ERR;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign err = (state == S_ERR);
    assign out = (state == S_NUM || state == S_CLOSE) && (depth == '0);

endmodule

// File: tb/tb_expr_stream_checker.sv
`timescale 1ns/1ps
module tb_expr_stream_checker;

    localparam int DEPTH_W = 2;
    localparam int CNT_W   = 8;

    typedef struct packed {
        logic               o;
        logic               e;
        logic [DEPTH_W-1:0] d;
        logic [CNT_W-1:0]   t;
    } exp_t;

    logic               clk = 1'b0;
    logic               clr_n = 1'b0;
    logic               in_valid = 1'b0;
    logic [7:0]         in = 8'h00;
    logic               out;
    logic               err;
    logic [DEPTH_W-1:0] depth;
    logic [CNT_W-1:0]   term_cnt;

    int    n_checks = 0;
    int    n_pass   = 0;
    string phase    = "reset";
    exp_t  sb[$];
    exp_t  cur = '0;
    logic  acc_s, rst_s;

    expr_stream_checker #(
        .MAX_DIGITS (4),
        .MAX_DEPTH  (3),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .in_valid (in_valid),
        .in       (in),
        .out      (out),
        .err      (err),
        .depth    (depth),
        .term_cnt (term_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s %s: got %0d expected %0d", phase, tag, got, exp);
    endtask

    // Monitor: retire one expectation per accepted byte, compare every cycle.
    always @(posedge clk) begin
        acc_s = in_valid;
        rst_s = !clr_n;
        #1;
        if (rst_s) begin
            cur = '0;
            sb.delete();
        end else if (acc_s) begin
            if (sb.size() == 0) check("sb_underflow", 32'(1), 32'(0));
            else cur = sb.pop_front();
        end
        check("out",      32'(out),      32'(cur.o));
        check("err",      32'(err),      32'(cur.e));
        check("depth",    32'(depth),    32'(cur.d));
        check("term_cnt", 32'(term_cnt), 32'(cur.t));
    end

    task automatic send(input logic [7:0] c, input logic o, input logic e,
                        input int d, input int t);
        exp_t x;
        x.o = o;
        x.e = e;
        x.d = DEPTH_W'(d);
        x.t = CNT_W'(t);
        sb.push_back(x);
        in       = c;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in       = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        idle(2);
        clr_n = 1'b1;
        idle(1);

        phase = "mixed_ops";
        send("1", 1, 0, 0, 1);
        send("2", 1, 0, 0, 1);
        send("+", 0, 0, 0, 1);
        send("3", 1, 0, 0, 2);
        send("4", 1, 0, 0, 2);
        send("5", 1, 0, 0, 2);
        send("*", 0, 0, 0, 2);
        send("6", 1, 0, 0, 3);
        do_reset();

        phase = "nested";
        send("(", 0, 0, 1, 0);
        send("7", 0, 0, 1, 1);
        send("-", 0, 0, 1, 1);
        send("(", 0, 0, 2, 1);
        send("8", 0, 0, 2, 2);
        send("/", 0, 0, 2, 2);
        send("9", 0, 0, 2, 3);
        send(")", 0, 0, 1, 3);
        send(")", 1, 0, 0, 3);
        do_reset();

        phase = "max_digits";
        send("1", 1, 0, 0, 1);
        send("2", 1, 0, 0, 1);
        send("3", 1, 0, 0, 1);
        send("4", 1, 0, 0, 1);
        send("5", 0, 1, 0, 1);
        send("6", 0, 1, 0, 1);
        send("+", 0, 1, 0, 1);
        idle(2);
        do_reset();

        phase = "four_digit_ops";
        send("9", 1, 0, 0, 1);
        send("9", 1, 0, 0, 1);
        send("9", 1, 0, 0, 1);
        send("9", 1, 0, 0, 1);
        send("+", 0, 0, 0, 1);
        send("0", 1, 0, 0, 2);
        send("0", 1, 0, 0, 2);
        send("0", 1, 0, 0, 2);
        send("7", 1, 0, 0, 2);
        do_reset();

        phase = "max_depth";
        send("(", 0, 0, 1, 0);
        send("(", 0, 0, 2, 0);
        send("(", 0, 0, 3, 0);
        send("(", 0, 1, 3, 0);
        send("1", 0, 1, 3, 0);
        send(")", 0, 1, 3, 0);
        do_reset();
        idle(1);

        phase = "gaps";
        send("3", 1, 0, 0, 1);
        idle(5);
        send("+", 0, 0, 0, 1);
        idle(5);
        send("x", 0, 1, 0, 1);
        idle(2);
        do_reset();

        phase = "rp_underflow";
        send("1", 1, 0, 0, 1);
        send(")", 0, 1, 0, 1);
        do_reset();

        phase = "empty_parens";
        send("(", 0, 0, 1, 0);
        send(")", 0, 1, 1, 0);
        do_reset();

        phase = "leading_op";
        send("-", 0, 1, 0, 0);
        do_reset();

        phase = "space_expr";
`ifdef EXPR_SPACE_SKIP_EN
        send("1",   1, 0, 0, 1);
        send(8'h20, 1, 0, 0, 1);
        send("+",   0, 0, 0, 1);
        send(8'h09, 0, 0, 0, 1);
        send("2",   1, 0, 0, 2);
`else
        send("1",   1, 0, 0, 1);
        send(8'h20, 0, 1, 0, 1);
        send("+",   0, 1, 0, 1);
        send(8'h20, 0, 1, 0, 1);
        send("2",   0, 1, 0, 1);
`endif
        do_reset();

        phase = "space_in_num";
        send("1", 1, 0, 0, 1);
`ifdef EXPR_SPACE_SKIP_EN
        send(8'h20, 1, 0, 0, 1);
`else
        send(8'h20, 0, 1, 0, 1);
`endif
        send("2", 0, 1, 0, 1);
        do_reset();

        phase = "term_saturate";
        send("1", 1, 0, 0, 1);
        for (int k = 2; k <= 300; k++) begin
            send("+", 0, 0, 0, (k - 1 > 255) ? 255 : k - 1);
            send("1", 1, 0, 0, (k > 255) ? 255 : k);
        end
        idle(2);

        phase = "drain";
        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
